// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit for an in-order pipeline.
// A small tracker shadows EX and the NSTAGE producer stages behind it.
module fwd_hazard_unit #(
    parameter  int ADDR_W   = 5,
    parameter  int NSTAGE   = 2,
    parameter  int LOAD_LAT = 1,
    localparam int SW       = $clog2(NSTAGE + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    output logic [SW-1:0]     fwd_a,
    output logic [SW-1:0]     fwd_b,
    output logic [15:0]       stall_cnt
);

    // Entry 0 is the instruction in EX; entry k is producer stage k.
    logic              r_v  [0:NSTAGE];
    logic [ADDR_W-1:0] r_rd [0:NSTAGE];
    logic              r_wr [0:NSTAGE];
    logic              r_ld [0:NSTAGE];
    logic [ADDR_W-1:0] r_ex_rs1;
    logic [ADDR_W-1:0] r_ex_rs2;
    logic [15:0]       r_stall_cnt;

    logic              w_load_hit;
    logic              w_stall;
    logic [SW-1:0]     w_fwd_a;
    logic [SW-1:0]     w_fwd_b;

    // A load still short of LOAD_LAT cannot supply its data yet, so a
    // dependent ID instruction must wait.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_load_hit = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (r_v[k] && r_wr[k] && r_ld[k] && (r_rd[k] != '0) &&
                ((r_rd[k] == id_rs1) || (r_rd[k] == id_rs2))) begin
                w_load_hit = 1'b1;
            end
        end
        w_stall = id_valid && !flush && w_load_hit;
    end

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        w_fwd_a = '0;
        w_fwd_b = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (r_v[k] && r_wr[k] && (!r_ld[k] || (k >= LOAD_LAT))) begin
                if ((r_ex_rs1 != '0) && (r_rd[k] == r_ex_rs1)) begin
                    w_fwd_a = SW'(k);
                end
                if ((r_ex_rs2 != '0) && (r_rd[k] == r_ex_rs2)) begin
                    w_fwd_b = SW'(k);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
        if (rst) begin
            for (int k = 0; k <= NSTAGE; k++) begin
                r_v[k]  <= 1'b0;
                r_rd[k] <= '0;
                r_wr[k] <= 1'b0;
                r_ld[k] <= 1'b0;
            end
            r_ex_rs1    <= '0;
            r_ex_rs2    <= '0;
            r_stall_cnt <= '0;
        end else if (!hold) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                r_v[k]  <= r_v[k-1];
                r_rd[k] <= r_rd[k-1];
                r_wr[k] <= r_wr[k-1];
                r_ld[k] <= r_ld[k-1];
            end
            if (w_stall || flush) begin
                r_v[0]   <= 1'b0;
                r_rd[0]  <= '0;
                r_wr[0]  <= 1'b0;
                r_ld[0]  <= 1'b0;
                r_ex_rs1 <= '0;
                r_ex_rs2 <= '0;
            end else begin
                r_v[0]   <= id_valid;
                r_rd[0]  <= id_rd;
                r_wr[0]  <= id_regwrite && id_valid;
                r_ld[0]  <= id_memread && id_valid;
                r_ex_rs1 <= id_rs1;
                r_ex_rs2 <= id_rs2;
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign stall     = w_stall;
    assign fwd_a     = w_fwd_a;
    assign fwd_b     = w_fwd_b;
    assign stall_cnt = r_stall_cnt;

endmodule
